// File: rtl/cnnip_conv_seq.sv
// cnnip_conv_seq - convolution sequencer for the CNN IP (clock domain a).
// On a valid start it loads a KxK kernel from weight memory, then walks every
// valid output position: it reads the KxK input window, multiply-accumulates
// signed data and writes one result per position to feature memory.
// Ports:
//   clk_a, arstz_aq             clock, asynchronous active-low reset
//   cmd_start                   start request (level, sampled in IDLE)
//   mode_kernel_size/stride     run-time kernel side K and stride S
//   busy, cmd_done, cmd_err     status: not idle / end-of-run / rejected start
//   w_en/w_addr/w_dout/w_valid  weight memory read port (1-cycle latency)
//   in_en/in_addr/in_dout/in_valid  input memory read port (1-cycle latency)
//   fm_en/fm_we/fm_addr/fm_din  feature memory write port
module cnnip_conv_seq #(
    parameter int unsigned IMG_W  = 32,
    parameter int unsigned IMG_H  = 32,
    parameter int unsigned MAX_K  = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk_a,
    input  logic              arstz_aq,
    input  logic              cmd_start,
    input  logic [3:0]        mode_kernel_size,
    input  logic [1:0]        mode_stride,
    output logic              busy,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_dout,
    input  logic              w_valid,
    output logic              in_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_dout,
    input  logic              in_valid,
    output logic              fm_en,
    output logic              fm_we,
    output logic [ADDR_W-1:0] fm_addr,
    output logic [ACC_W-1:0]  fm_din
);

    localparam int unsigned NW   = MAX_K * MAX_K;
    localparam int unsigned WI_W = $clog2(NW + 1);

    typedef enum logic [2:0] {
        IDLE, LDW, LDW_WAIT, CONV, DRAIN, WRITE, DONE
    } state_t;

    state_t state, state_nxt;

    logic [3:0]               k_q;
    logic [1:0]               s_q;
    logic [3:0]               kr_q, kc_q;
    logic [WI_W-1:0]          idx_q, pidx_q;
    logic [ADDR_W-1:0]        r_q, c_q, fm_idx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] weight_q [NW];
    logic                     err_q;

    logic                       cfg_bad, k_last, c_fits, r_fits, pix_last;
    logic [ADDR_W-1:0]          c_end, r_end, win_addr;
    logic signed [2*DATA_W-1:0] prod;

    assign cfg_bad = (mode_kernel_size == 4'd0) ||
                     (32'(mode_kernel_size) > MAX_K) ||
                     (32'(mode_kernel_size) > IMG_W) ||
                     (32'(mode_kernel_size) > IMG_H) ||
                     (mode_stride == 2'd0);

    assign k_last   = (kr_q == k_q - 4'd1) && (kc_q == k_q - 4'd1);
    assign c_end    = c_q + ADDR_W'(s_q) + ADDR_W'(k_q);
    assign r_end    = r_q + ADDR_W'(s_q) + ADDR_W'(k_q);
    assign c_fits   = c_end <= ADDR_W'(IMG_W);
    assign r_fits   = r_end <= ADDR_W'(IMG_H);
    assign pix_last = !c_fits && !r_fits;
    assign win_addr = (r_q + ADDR_W'(kr_q)) * ADDR_W'(IMG_W) + c_q + ADDR_W'(kc_q);
    // pidx_q is the kernel index issued one cycle ago, matching the returning data
    assign prod     = $signed(in_dout) * weight_q[pidx_q];

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cmd_start && !cfg_bad) state_nxt = LDW;
            LDW:      if (k_last) state_nxt = LDW_WAIT;
            LDW_WAIT: state_nxt = CONV;
            CONV:     if (k_last) state_nxt = DRAIN;
            DRAIN:    state_nxt = WRITE;
            WRITE:    state_nxt = pix_last ? DONE : CONV;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        cmd_done = (state == DONE);
        cmd_err  = err_q;
        w_en     = 1'b0;
        w_addr   = '0;
        in_en    = 1'b0;
        in_addr  = '0;
        fm_en    = 1'b0;
        fm_we    = 1'b0;
        fm_addr  = '0;
        fm_din   = '0;
        case (state)
            LDW: begin
                w_en   = 1'b1;
                w_addr = ADDR_W'(idx_q);
            end
            CONV: begin
                in_en   = 1'b1;
                in_addr = win_addr;
            end
            WRITE: begin
                fm_en   = 1'b1;
                fm_we   = 1'b1;
                fm_addr = fm_idx_q;
                fm_din  = acc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            k_q      <= '0;
            s_q      <= '0;
            kr_q     <= '0;
            kc_q     <= '0;
            idx_q    <= '0;
            pidx_q   <= '0;
            r_q      <= '0;
            c_q      <= '0;
            fm_idx_q <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NW; i++) weight_q[i] <= '0;
        end else begin
            err_q <= (state == IDLE) && cmd_start && cfg_bad;
            case (state)
                IDLE: if (cmd_start && !cfg_bad) begin
                    k_q      <= mode_kernel_size;
                    s_q      <= mode_stride;
                    kr_q     <= '0;
                    kc_q     <= '0;
                    idx_q    <= '0;
                    pidx_q   <= '0;
                    r_q      <= '0;
                    c_q      <= '0;
                    fm_idx_q <= '0;
                    acc_q    <= '0;
                end
                LDW, CONV: begin
                    pidx_q <= idx_q;
                    // counters wrap to zero on the last issue, ready for the next window
                    if (k_last) begin
                        kr_q  <= '0;
                        kc_q  <= '0;
                        idx_q <= '0;
                    end else if (kc_q == k_q - 4'd1) begin
                        kc_q  <= '0;
                        kr_q  <= kr_q + 4'd1;
                        idx_q <= idx_q + WI_W'(1);
                    end else begin
                        kc_q  <= kc_q + 4'd1;
                        idx_q <= idx_q + WI_W'(1);
                    end
                    if (state == LDW) begin
                        if (w_valid && idx_q != '0) weight_q[pidx_q] <= $signed(w_dout);
                    end else if (idx_q == '0) begin
                        acc_q <= '0;
                    end else if (in_valid) begin
                        acc_q <= acc_q + ACC_W'(prod);
                    end
                end
                LDW_WAIT: if (w_valid) weight_q[pidx_q] <= $signed(w_dout);
                DRAIN:    if (in_valid) acc_q <= acc_q + ACC_W'(prod);
                WRITE: begin
                    fm_idx_q <= fm_idx_q + ADDR_W'(1);
                    if (c_fits) begin
                        c_q <= c_q + ADDR_W'(s_q);
                    end else begin
                        c_q <= '0;
                        if (r_fits) r_q <= r_q + ADDR_W'(s_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnnip_conv_seq.sv
// tb_cnnip_conv_seq - self-checking bench for cnnip_conv_seq.
// Memory models answer reads one cycle after the enable. A reference model
// computes expected read addresses and feature writes per run; a compare
// process checks every memory access against it.
module tb_cnnip_conv_seq;

    localparam int IMG_W = 32, IMG_H = 32, MAX_K = 7;
    localparam int DATA_W = 8, ACC_W = 32, ADDR_W = 12;

    logic              clk_a = 1'b0;
    logic              arstz_aq = 1'b0;
    logic              cmd_start = 1'b0;
    logic [3:0]        mode_kernel_size = '0;
    logic [1:0]        mode_stride = '0;
    logic              busy, cmd_done, cmd_err;
    logic              w_en, in_en, fm_en, fm_we;
    logic [ADDR_W-1:0] w_addr, in_addr, fm_addr;
    logic [DATA_W-1:0] w_dout = '0, in_dout = '0;
    logic              w_valid = 1'b0, in_valid = 1'b0;
    logic [ACC_W-1:0]  fm_din;

    cnnip_conv_seq #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .MAX_K(MAX_K),
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_a(clk_a), .arstz_aq(arstz_aq), .cmd_start(cmd_start),
        .mode_kernel_size(mode_kernel_size), .mode_stride(mode_stride),
        .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .w_en(w_en), .w_addr(w_addr), .w_dout(w_dout), .w_valid(w_valid),
        .in_en(in_en), .in_addr(in_addr), .in_dout(in_dout), .in_valid(in_valid),
        .fm_en(fm_en), .fm_we(fm_we), .fm_addr(fm_addr), .fm_din(fm_din)
    );

    always #5 clk_a = ~clk_a;

    int cyc = 0;
    always @(posedge clk_a) cyc <= cyc + 1;

    logic [7:0] in_mem [IMG_W*IMG_H];
    logic [7:0] w_mem  [64];

    always @(posedge clk_a) begin
        w_valid  <= w_en;
        w_dout   <= w_mem[w_addr[5:0]];
        in_valid <= in_en;
        in_dout  <= in_mem[in_addr[9:0]];
    end

    int n_assert = 0, n_fail = 0;
    int n_writes = 0, n_err = 0, done_cyc = 0;
    logic [31:0] last_fm_din = '0, last_in_addr = '0;
    int unsigned exp_w[$], exp_in[$];
    logic [31:0] exp_fa[$], exp_fd[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // compare process: every memory access against the model queues
    always @(negedge clk_a) begin
        if (arstz_aq) begin
            if (w_en || in_en || fm_en) chk("en_onehot", $countones({w_en, in_en, fm_en}), 1);
            if (w_en) chk("w_addr", 32'(w_addr), exp_w.size() != 0 ? exp_w.pop_front() : 32'hFFFF_FFFF);
            if (in_en) begin
                chk("in_addr", 32'(in_addr), exp_in.size() != 0 ? exp_in.pop_front() : 32'hFFFF_FFFF);
                last_in_addr = 32'(in_addr);
            end
            if (fm_en) begin
                chk("fm_we", 32'(fm_we), 1);
                if (exp_fa.size() != 0) begin
                    chk("fm_addr", 32'(fm_addr), exp_fa.pop_front());
                    chk("fm_din", fm_din, exp_fd.pop_front());
                end else begin
                    chk("fm_extra_write", 32'(fm_addr), 32'hFFFF_FFFF);
                end
                n_writes++;
                last_fm_din = fm_din;
            end
            if (cmd_err) n_err++;
        end
    end

    // reference model: reads and results straight from the convolution definition
    task automatic build(input int k, input int s);
        int ow, oh, a, sum, iv, wv;
        exp_w.delete(); exp_in.delete(); exp_fa.delete(); exp_fd.delete();
        for (int i = 0; i < k*k; i++) exp_w.push_back(i);
        ow = (IMG_W - k) / s + 1;
        oh = (IMG_H - k) / s + 1;
        for (int ro = 0; ro < oh; ro++)
            for (int co = 0; co < ow; co++) begin
                sum = 0;
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        a = (ro*s + kr) * IMG_W + co*s + kc;
                        exp_in.push_back(a);
                        iv = $signed(in_mem[a]);
                        wv = $signed(w_mem[kr*k + kc]);
                        sum += iv * wv;
                    end
                exp_fa.push_back(ro*ow + co);
                exp_fd.push_back(sum);
            end
    endtask

    task automatic fill(input logic [7:0] iv, input logic [7:0] wv);
        for (int i = 0; i < IMG_W*IMG_H; i++) in_mem[i] = iv;
        for (int i = 0; i < 64; i++) w_mem[i] = wv;
    endtask

    task automatic fill_pattern(input int im, input int wm, input int wo);
        for (int i = 0; i < IMG_W*IMG_H; i++) in_mem[i] = 8'((i*im + 11) & 255);
        for (int i = 0; i < 64; i++) w_mem[i] = 8'((i*wm + wo) & 255);
    endtask

    task automatic run(input int k, input int s, input bit hold, input int abort_pix);
        int ow, oh, exp_done, c0;
        bit done;
        build(k, s);
        n_writes = 0; n_err = 0;
        ow = (IMG_W - k) / s + 1;
        oh = (IMG_H - k) / s + 1;
        exp_done = 1 + (k*k + 1) + ow*oh*(k*k + 2);
        @(negedge clk_a);
        cmd_start = 1'b1;
        mode_kernel_size = 4'(k);
        mode_stride = 2'(s);
        c0 = cyc;
        done = 1'b0;
        for (int i = 1; i <= exp_done + 50 && !done; i++) begin
            @(negedge clk_a);
            if (i == 1) begin
                chk("busy_cycle1", 32'(busy), 1);
                if (!hold) cmd_start = 1'b0;
                mode_kernel_size = 4'd0;   // config must already be latched
                mode_stride = 2'd0;
            end
            if (abort_pix >= 0 && n_writes == abort_pix && in_en) begin
                arstz_aq = 1'b0;
                cmd_start = 1'b0;
                exp_w.delete(); exp_in.delete(); exp_fa.delete(); exp_fd.delete();
                #1;
                chk("abort_ctrl", {29'd0, busy, cmd_done, cmd_err}, 0);
                chk("abort_en", {28'd0, w_en, in_en, fm_en, fm_we}, 0);
                chk("abort_addr", {w_addr, in_addr, 8'd0} | 32'(fm_addr), 0);
                chk("abort_din", fm_din, 0);
                repeat (3) begin
                    @(negedge clk_a);
                    chk("reset_quiet", {28'd0, w_en, in_en, fm_en, busy}, 0);
                end
                chk("abort_writes", n_writes, abort_pix);
                arstz_aq = 1'b1;
                return;
            end
            if (cmd_done) begin
                done = 1'b1;
                done_cyc = cyc - c0;
                chk("done_cycle", done_cyc, exp_done);
            end
        end
        chk("done_seen", 32'(done), 1);
        cmd_start = 1'b0;
        @(negedge clk_a);
        chk("idle_busy", 32'(busy), 0);
        chk("done_pulse", 32'(cmd_done), 0);
        chk("w_left", exp_w.size(), 0);
        chk("in_left", exp_in.size(), 0);
        chk("fm_left", exp_fa.size(), 0);
        chk("no_err", n_err, 0);
        repeat (3) @(negedge clk_a);
        chk("stays_idle", {30'd0, busy, w_en | in_en | fm_en}, 0);
    endtask

    task automatic bad_start(input int k, input int s);
        @(negedge clk_a);
        cmd_start = 1'b1;
        mode_kernel_size = 4'(k);
        mode_stride = 2'(s);
        @(negedge clk_a);
        cmd_start = 1'b0;
        chk("err_pulse", 32'(cmd_err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_no_en", {29'd0, w_en, in_en, fm_en}, 0);
        @(negedge clk_a);
        chk("err_once", 32'(cmd_err), 0);
        chk("err_busy2", 32'(busy), 0);
    endtask

    initial begin
        fill(8'd1, 8'd1);
        repeat (3) @(negedge clk_a);
        chk("rst_ctrl", {29'd0, busy, cmd_done, cmd_err}, 0);
        chk("rst_en", {28'd0, w_en, in_en, fm_en, fm_we}, 0);
        chk("rst_din", fm_din, 0);
        arstz_aq = 1'b1;
        @(negedge clk_a);

        // 1: K=5 S=1, all ones
        run(5, 1, 1'b0, -1);
        chk("t1_writes", n_writes, 784);
        chk("t1_din", last_fm_din, 25);
        chk("t1_done_lit", done_cyc, 21195);

        // 2: K=3 S=2, all ones
        run(3, 2, 1'b0, -1);
        chk("t2_writes", n_writes, 225);
        chk("t2_din", last_fm_din, 9);
        chk("t2_last_in", last_in_addr, 990);

        // 3: K=3 S=1, inputs -1, weights 2
        fill(8'hFF, 8'd2);
        run(3, 1, 1'b0, -1);
        chk("t3_writes", n_writes, 900);
        chk("t3_din", last_fm_din, 32'hFFFF_FFEE);

        // 4: rejected configurations
        n_err = 0;
        bad_start(0, 1);
        bad_start(8, 1);
        bad_start(3, 0);
        chk("t4_err_count", n_err, 3);

        // 5: start held high through a K=1 run
        for (int i = 0; i < IMG_W*IMG_H; i++) in_mem[i] = 8'((i*7) & 255);
        for (int i = 0; i < 64; i++) w_mem[i] = 8'hFD;
        run(1, 1, 1'b1, -1);
        chk("t5_writes", n_writes, 1024);
        chk("t5_din", last_fm_din, 21);

        // signed mixed data, strides not dividing the image, largest kernel
        fill_pattern(37, 53, 200);
        run(4, 3, 1'b0, -1);
        chk("t7_writes", n_writes, 100);
        run(7, 3, 1'b0, -1);
        chk("t8_writes", n_writes, 81);

        // 6: reset during CONV of pixel 10, then a clean run
        run(3, 1, 1'b0, 10);
        @(negedge clk_a);
        chk("t6_no_write", n_writes, 10);
        run(3, 2, 1'b0, -1);
        chk("t6_writes", n_writes, 225);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cnnip_conv_seq.md
Name: cnnip_conv_seq

Overview:
Parametrised convolution sequencer for the CNN IP. It supersedes the fixed 32x32 / 5x5 / 784-pixel controller with run-time kernel size and stride over a compile-time image size. On a start command it loads the kernel from weight memory. It then walks every valid output position: it issues input-memory reads, multiply-accumulates signed data, and writes each result to feature memory. Sits between the config register block and the three internal memories in clock domain a.

Parameters:
IMG_W, 32, input image width (pixels)
IMG_H, 32, input image height (pixels)
MAX_K, 7, largest supported kernel side
DATA_W, 8, signed input/weight data width
ACC_W, 32, signed accumulator and feature data width
ADDR_W, 12, memory address width

Ports:
clk_a  in  1  clock
arstz_aq  in  1  async reset, active-low
cmd_start  in  1  start request (level, sampled in IDLE only)
mode_kernel_size  in  4  kernel side K
mode_stride  in  2  stride S
busy  out  1  high in any state except IDLE
cmd_done  out  1  one-cycle pulse at end of run
cmd_err  out  1  one-cycle pulse on rejected start
w_en  out  1  weight mem read enable
w_addr  out  ADDR_W  weight read address
w_dout  in  DATA_W  weight read data
w_valid  in  1  weight data valid
in_en  out  1  input mem read enable
in_addr  out  ADDR_W  input read address
in_dout  in  DATA_W  input read data
in_valid  in  1  input data valid
fm_en  out  1  feature mem enable
fm_we  out  1  feature mem write enable
fm_addr  out  ADDR_W  feature write address
fm_din  out  ACC_W  feature write data

Behaviour:
- Clock clk_a; reset arstz_aq is asynchronous, active-low. In reset: state IDLE; all outputs 0; counters, accumulator and weight registers 0.
- Memories have a fixed 1-cycle read latency. Valid is high in the cycle after the matching en.
- Config check in IDLE on cmd_start. The config is invalid if K=0, K>MAX_K, K>IMG_W, K>IMG_H or S=0.
  - Invalid: cmd_err pulses the next cycle; state stays IDLE; no memory access.
  - Valid: K and S are latched, and state goes to LDW.
- cmd_start is ignored while busy. Config inputs are ignored after they are latched.
- LDW: K*K cycles. Cycle i drives w_en=1, w_addr=i (raster, i=0..K*K-1).
  - On w_valid, w_dout is stored into weight register [index of previous issue].
  - After the last issue, go to LDW_WAIT.
- LDW_WAIT: 1 cycle; captures the last weight; then CONV. Output position (r,c)=(0,0); fm index=0.
- CONV: K*K cycles per output pixel.
  - Kernel position (kr,kc) in raster order; in_en=1, in_addr=(r+kr)*IMG_W+(c+kc).
  - Accumulator is cleared on the first issue of each pixel.
  - On in_valid: acc += sext(in_dout)*sext(weight[kr,kc]) for the matching previous issue.
  - After the last issue, go to DRAIN.
- DRAIN: 1 cycle; the last product is accumulated; then WRITE.
- WRITE: 1 cycle; fm_en=fm_we=1, fm_addr=fm index, fm_din=acc (wraps modulo 2^ACC_W, no saturation). Then step position:
  - c+=S if c+S+K<=IMG_W;
  - else c=0, r+=S if r+S+K<=IMG_H;
  - else last pixel: go to DONE.
  - fm index increments per write. Non-last: back to CONV.
- DONE: cmd_done=1 for one cycle, then IDLE.
- Output dims: OW=floor((IMG_W-K)/S)+1, OH=floor((IMG_H-K)/S)+1.
- Latency: start sampled in cycle 0 gives cmd_done in cycle 1 + (K*K+1) + OH*OW*(K*K+2).
- Only one of w_en / in_en / fm_en is high in any cycle.
- Reset mid-operation aborts immediately. No further memory accesses occur; cmd_done is not asserted.
- Spurious valid outside LDW/LDW_WAIT/CONV/DRAIN is ignored.

Test Plan:
1. IMG 32x32, K=5, S=1, all inputs 1, all weights 1: 784 writes at fm_addr 0..783, each fm_din=25. cmd_done in cycle 21195. busy high cycles 1..21195.
2. K=3, S=2, inputs 1, weights 1: 225 writes (15x15), each fm_din=9. The last input read addr is 30*32+30=990.
3. K=3, S=1, inputs 0xFF (-1), weights 2: each fm_din=0xFFFFFFEE (-18); 900 writes.
4. K=0, then K=8, then S=0 with cmd_start: cmd_err pulses once each; no en asserted; busy stays 0.
5. cmd_start held high through a K=1, S=1 run: exactly one run of 1024 writes, fm_din=input*weight. The second run starts only from IDLE after cmd_done.
6. arstz_aq low during CONV of pixel 10: all outputs 0 the same cycle; no fm write for pixel 10. A following valid start runs cleanly from fm_addr 0.
